// File: rtl/display_rx.sv
// display_rx: pixel-domain timing receiver recovering coordinates, sync totals and a lock state.
// Define DISPLAY_RX_ERRCNT_EN to build the saturating err_cnt counter; otherwise err_cnt is 0.
module display_rx #(
  parameter int CORDW = 16,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int H_POL = 0,
  parameter int V_POL = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                    clk_pix,
  input  logic                    rst_pix_n,
  input  logic                    hsync,
  input  logic                    vsync,
  input  logic                    de,
  output logic signed [CORDW-1:0] sx,
  output logic signed [CORDW-1:0] sy,
  output logic                    de_out,
  output logic                    line,
  output logic                    frame,
  output logic [CORDW-1:0]        h_total,
  output logic [CORDW-1:0]        v_total,
  output logic                    locked,
  output logic                    err,
  output logic [7:0]              err_cnt
);
  localparam logic signed [CORDW-1:0] SMAX = {1'b0, {(CORDW-1){1'b1}}};
  localparam logic signed [CORDW-1:0] H_LAST = CORDW'(H_RES - 1);
  localparam logic signed [CORDW-1:0] V_LAST = CORDW'(V_RES - 1);
  typedef enum logic [1:0] {IDLE, TRAIN, LOCKED} state_t;
  state_t state;
  logic hs_r, vs_r, de_r, hs_q, vs_q;
  logic [CORDW-1:0] h_cnt, v_cnt, h_prev, h_new;
  logic frame_bad, prev_ok;
  logic [3:0] good;
  logic hs_rise, vs_rise, de_rise, run_bad, bad;
  // de_out doubles as the delayed copy of de_r for edge detection
  assign hs_rise = hs_r & ~hs_q;
  assign vs_rise = vs_r & ~vs_q;
  assign de_rise = de_r & ~de_out;
  assign run_bad = ~de_r & de_out & (sx != H_LAST);
  assign h_new = hs_rise ? h_cnt : h_total;
  // totals are only compared once the previous frame was a full, checked one
  assign bad = frame_bad | run_bad | (sy != V_LAST) |
               (prev_ok & ((h_new != h_prev) | (v_cnt != v_total)));
  always_ff @(posedge clk_pix or negedge rst_pix_n)
    if (!rst_pix_n) begin
      {hs_r, vs_r, de_r, hs_q, vs_q, de_out, line, frame, frame_bad} <= '0;
      sx <= '1;
      sy <= '1;
      {h_cnt, v_cnt, h_total, v_total, h_prev} <= '0;
    end else begin
      hs_r <= hsync == 1'(H_POL);
      vs_r <= vsync == 1'(V_POL);
      de_r <= de;
      hs_q <= hs_r;
      vs_q <= vs_r;
      de_out <= de_r;
      line <= de_rise;
      frame <= de_rise & ~vs_rise & (sy == '1);
      sx <= !de_r ? '1 : de_rise ? '0 : (sx == SMAX) ? sx : sx + 1'b1;
      sy <= vs_rise ? '1 : (de_rise && sy != SMAX) ? sy + 1'b1 : sy;
      h_cnt <= hs_rise ? CORDW'(1) : (&h_cnt) ? h_cnt : h_cnt + 1'b1;
      v_cnt <= vs_rise ? CORDW'(hs_rise) : (hs_rise && !(&v_cnt)) ? v_cnt + 1'b1 : v_cnt;
      if (hs_rise) h_total <= h_cnt;
      if (vs_rise) begin
        v_total <= v_cnt;
        h_prev <= h_new;
      end
      frame_bad <= vs_rise ? 1'b0 : frame_bad | run_bad;
    end
  always_ff @(posedge clk_pix or negedge rst_pix_n)
    if (!rst_pix_n) begin
      state <= IDLE;
      good <= '0;
      locked <= 1'b0;
      err <= 1'b0;
      prev_ok <= 1'b0;
    end else begin
      err <= 1'b0;
      if (vs_rise) begin
        prev_ok <= state != IDLE;
        if (state == IDLE) begin
          state <= TRAIN;
          good <= '0;
        end else if (bad) begin
          err <= 1'b1;
          locked <= 1'b0;
          state <= TRAIN;
          good <= '0;
        end else if (state == TRAIN) begin
          good <= good + 1'b1;
          if (good + 1'b1 == 4'(LOCK_FRAMES)) begin
            state <= LOCKED;
            locked <= 1'b1;
          end
        end
      end
    end
`ifdef DISPLAY_RX_ERRCNT_EN
  always_ff @(posedge clk_pix or negedge rst_pix_n)
    if (!rst_pix_n) err_cnt <= '0;
    else if (err && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
`else
  assign err_cnt = '0;
`endif
endmodule
